// File: rtl/drum_pkg.sv
// Shared helpers for the pipelined DRUM approximate multiplier: width math and
// the leading-one priority encoder used by the operand truncation stage.
package drum_pkg;

  // Widest operand the leading-one scan supports.
  localparam int unsigned MAX_W = 128;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r++;
    end
    return r;
  endfunction

  // Width of the combined shift amount pA+pB, whose maximum is 2*(WIDTH-K).
  // A package cannot see module generics, so this is a function of them.
  function automatic int unsigned shift_w(input int unsigned width, input int unsigned k);
    return clog2(2 * (width - k) + 1);
  endfunction

  function automatic int unsigned lead_one_idx(input logic [MAX_W-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/drum_trunc.sv
// Per-operand front end: magnitude, leading-one detection and DRUM truncation
// to a K-bit mantissa m with shift p. Purely combinational.
module drum_trunc import drum_pkg::*; #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned K     = 6
) (
  input  logic [WIDTH-1:0]              x,
  input  logic                          is_signed,
  output logic [K-1:0]                  m,
  output logic [shift_w(WIDTH, K)-1:0]  p,
  output logic                          is_zero
);

  localparam int unsigned SW = shift_w(WIDTH, K);

  logic [WIDTH-1:0] mag;
  int unsigned      lead;

  always_comb begin
    // WIDTH-bit unsigned negation: the most negative value maps to 2^(WIDTH-1).
    mag     = (is_signed && x[WIDTH-1]) ? -x : x;
    lead    = lead_one_idx(MAX_W'(mag));
    is_zero = (mag == '0);
    if (lead >= K) begin
      // Keep the leading one and the next K-2 bits, force the LSB to one.
      m = K'(mag >> (lead - K + 1)) | K'(1);
      p = SW'(lead - K + 1);
    end else begin
      m = mag[K-1:0];
      p = '0;
    end
  end

endmodule

// File: rtl/drum_mult_pipe.sv
// Three-stage pipelined DRUM approximate multiplier with signed/unsigned mode,
// valid/ready handshake under a single global advance, and a tag sideband.
module drum_mult_pipe import drum_pkg::*; #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned K     = 6,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned SW = shift_w(WIDTH, K);
  localparam int unsigned PW = 2 * K;
  localparam int unsigned OW = 2 * WIDTH;

  logic adv;

  logic [K-1:0]  ma, mb;
  logic [SW-1:0] pa, pb;
  logic          za, zb;

  logic             s1_valid;
  logic [K-1:0]     s1_ma, s1_mb;
  logic [SW-1:0]    s1_psum;
  logic             s1_neg, s1_zero;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [PW-1:0]    s2_p;
  logic [SW-1:0]    s2_psum;
  logic             s2_neg, s2_zero;
  logic [TAG_W-1:0] s2_tag;

  logic [OW-1:0] s3_u, s3_next;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  drum_trunc #(
    .WIDTH(WIDTH),
    .K    (K)
  ) u_trunc_a (
    .x        (in_a),
    .is_signed(in_signed),
    .m        (ma),
    .p        (pa),
    .is_zero  (za)
  );

  drum_trunc #(
    .WIDTH(WIDTH),
    .K    (K)
  ) u_trunc_b (
    .x        (in_b),
    .is_signed(in_signed),
    .m        (mb),
    .p        (pb),
    .is_zero  (zb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ma    <= '0;
      s1_mb    <= '0;
      s1_psum  <= '0;
      s1_neg   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_tag   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ma   <= ma;
        s1_mb   <= mb;
        s1_psum <= pa + pb;
        s1_neg  <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        s1_zero <= za | zb;
        s1_tag  <= in_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_psum  <= '0;
      s2_neg   <= 1'b0;
      s2_zero  <= 1'b0;
      s2_tag   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p    <= PW'(s1_ma) * PW'(s1_mb);
        s2_psum <= s1_psum;
        s2_neg  <= s1_neg;
        s2_zero <= s1_zero;
        s2_tag  <= s1_tag;
      end
    end
  end

  // Max shift is 2*(WIDTH-K), so the 2K-bit product always fits in 2*WIDTH bits.
  always_comb begin
    s3_u = OW'(s2_p) << s2_psum;
    if (s2_zero) begin
      s3_next = '0;
    end else if (s2_neg) begin
      s3_next = -s3_u;
    end else begin
      s3_next = s3_u;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_product <= s3_next;
        out_tag     <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_drum_mult_pipe.sv
// Self-checking bench for drum_mult_pipe: arithmetic reference model with an
// in-order scoreboard, plus directed vectors with hand-computed products.
module tb_drum_mult_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned K     = 6;
  localparam int unsigned TAG_W = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_ready, in_signed;
  logic [WIDTH-1:0]     in_a, in_b;
  logic [TAG_W-1:0]     in_tag, out_tag;
  logic                 out_valid, out_ready;
  logic [2*WIDTH-1:0]   out_product;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  drum_mult_pipe #(
    .WIDTH(WIDTH),
    .K    (K),
    .TAG_W(TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_signed  (in_signed),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product),
    .out_tag    (out_tag)
  );

  typedef struct packed {
    logic [31:0] prod;
    logic [3:0]  tag;
  } exp_t;

  exp_t       expq[$];
  logic [3:0] seen_tags[$];
  exp_t       mon_e;
  logic       prev_stall = 1'b0;
  logic [31:0] prev_prod = '0;
  logic [3:0]  prev_tag  = '0;
  logic       saw_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // DRUM value of a magnitude: bits below p cleared, bit p forced to one.
  function automatic longint unsigned trunc_mag(input longint unsigned mag);
    int k;
    int p;
    k = -1;
    for (int i = 0; i < WIDTH; i++) begin
      if (mag[i]) k = i;
    end
    if (k < int'(K)) return mag;
    p = k - int'(K) + 1;
    return ((mag >> p) << p) | (64'd1 << p);
  endfunction

  function automatic logic [31:0] approx(input logic [15:0] a, input logic [15:0] b,
                                         input logic s);
    longint unsigned ma, mb, prod;
    logic [31:0] r;
    ma = (s && a[15]) ? 65536 - longint'(a) : longint'(a);
    mb = (s && b[15]) ? 65536 - longint'(b) : longint'(b);
    prod = trunc_mag(ma) * trunc_mag(mb);
    r = prod[31:0];
    if (s && (a[15] ^ b[15])) r = -r;
    return r;
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_product", 64'(out_product), 64'(prev_prod));
        check("hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid && !out_ready) check("in_ready_low_on_stall", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got tag %0d product 0x%0h, expected none",
                   out_tag, out_product);
        end else begin
          mon_e = expq.pop_front();
          check("stream_product", 64'(out_product), 64'(mon_e.prod));
          check("stream_tag", 64'(out_tag), 64'(mon_e.tag));
          seen_tags.push_back(out_tag);
        end
      end
      if (in_valid && in_ready) begin
        mon_e.prod = approx(in_a, in_b, in_signed);
        mon_e.tag  = in_tag;
        expq.push_back(mon_e);
      end
      prev_stall = out_valid && !out_ready;
      prev_prod  = out_product;
      prev_tag   = out_tag;
    end
  end

  // Called right after a posedge; returns right after the posedge that accepted the pair.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [3:0] tag);
    bit done;
    done = 1'b0;
    in_a = a; in_b = b; in_signed = s; in_tag = tag; in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else saw_stall = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [3:0] tag, input logic [31:0] exp);
    int cnt;
    cnt = 0;
    check({name, "_model"}, 64'(approx(a, b, s)), 64'(exp));
    @(posedge clk); #1;
    in_a = a; in_b = b; in_signed = s; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check({name, "_latency"}, 64'(cnt), 64'd3);
    check({name, "_product"}, 64'(out_product), 64'(exp));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && expq.size() != 0; c++) @(negedge clk);
    check("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    out_ready = 1'b1; saw_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_product", 64'(out_product), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    run_one("u_ff_ff",   16'h00FF, 16'h00FF, 1'b0, 4'd1, 32'h0000F810);
    run_one("u_exact",   16'd37,   16'd50,   1'b0, 4'd2, 32'd1850);
    run_one("u_max",     16'hFFFF, 16'hFFFF, 1'b0, 4'd3, 32'hF8100000);
    run_one("s_neg255",  16'hFF01, 16'h00FF, 1'b1, 4'd4, 32'hFFFF07F0);
    run_one("s_minint",  16'h8000, 16'h0001, 1'b1, 4'd5, 32'hFFFF7C00);
    run_one("s_zero",    16'h0000, 16'h8000, 1'b1, 4'd6, 32'h00000000);
    run_one("s_negneg",  16'hFFFF, 16'hFFFF, 1'b1, 4'd7, 32'h00000001);
    drain();

    // Backpressure: four back-to-back pairs while the consumer stalls 5 cycles.
    seen_tags.delete();
    saw_stall = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        send(16'd300, 16'd7,    1'b0, 4'd1);
        send(16'hFFF0, 16'd100, 1'b1, 4'd2);
        send(16'd1000, 16'd1000, 1'b0, 4'd3);
        send(16'd12,  16'hFFFD, 1'b1, 4'd4);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_saw_stall", 64'(saw_stall), 64'd1);
    check("bp_count", 64'(seen_tags.size()), 64'd4);
    for (int i = 0; i < 4 && i < seen_tags.size(); i++)
      check("bp_tag_order", 64'(seen_tags[i]), 64'(i + 1));

    // Random stream with random consumer backpressure and input gaps.
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
          send(16'($urandom), 16'($urandom), 1'($urandom), 4'(i));
        end
      end
      begin
        repeat (80) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two items in flight: neither may ever appear.
    seen_tags.delete();
    @(posedge clk); #1;
    in_a = 16'd500; in_b = 16'd600; in_signed = 1'b0; in_tag = 4'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_tag = 4'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_flush_valid", 64'(out_valid), 64'd0);
    check("rst_flush_product", 64'(out_product), 64'd0);
    repeat (8) @(negedge clk);
    check("rst_flush_none_emitted", 64'(seen_tags.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
